fetch_decode_buffer: RTL
========================

FETCH_DECODE_BUFFER -- requirements
Module: fetch_decode_buffer

Interface
REQ-001 Parameter: NOP_INSTR, 16'h0800, instruction word presented on out_instr when no entry is valid.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  fetch stage presents an instruction this cycle.
REQ-005 in_ready  output  1  buffer accepts the presented instruction this cycle.
REQ-006 in_instr  input  16  fetched instruction word.
REQ-007 in_pc_next  input  16  incremented PC (PC+2) paired with in_instr.
REQ-008 in_err  input  1  fetch error flag paired with in_instr.
REQ-009 flush  input  1  discard all buffered entries (branch/jump redirect).
REQ-010 out_valid  output  1  head entry valid for decode.
REQ-011 out_ready  input  1  decode consumes the head entry this cycle.
REQ-012 out_instr  output  16  head instruction, or NOP_INSTR when out_valid=0.
REQ-013 out_pc_next  output  16  head PC+2, or 16'h0000 when out_valid=0.
REQ-014 out_err  output  1  head error flag, 0 when out_valid=0.
REQ-015 halted  output  1  a HALT instruction has been accepted; further fetch blocked.
REQ-016 err_sticky  output  1  an accepted entry carried in_err=1 since last reset.
REQ-017 count  output  2  number of valid entries (0..2).

Function
REQ-018 Storage SHALL be a 2-entry FIFO of {instr[15:0], pc_next[15:0], err}, with 1-bit read and write pointers wrapping 1->0.
REQ-019 Occupancy states SHALL be EMPTY (count=0), ONE (count=1), FULL (count=2).
REQ-020 in_ready SHALL be combinational: 1 iff count<2, halted=0 and flush=0.
REQ-021 Write SHALL occur iff in_valid & in_ready; entry visible on out_* the next cycle (1-cycle latency, no combinational bypass).
REQ-022 Read SHALL occur iff out_valid & out_ready; head advances on that edge.
REQ-023 out_valid SHALL equal (count!=0); out_* driven combinationally from the head entry.
REQ-024 Simultaneous write and read in ONE SHALL keep count=1, with the new entry becoming head.
REQ-025 Simultaneous write and read are impossible in FULL (in_ready=0); a read in FULL SHALL move to ONE.
REQ-026 A read with out_ready=1 in EMPTY SHALL have no effect.
REQ-027 An accepted instruction with in_instr[15:11]==5'b00000 (HALT) SHALL set halted on that edge; the HALT entry itself is stored and delivered normally.
REQ-028 halted SHALL remain 1 until flush or rst; draining of already-stored entries SHALL continue while halted.
REQ-029 err_sticky SHALL set on acceptance of an entry with in_err=1 and clear only on rst.
REQ-030 flush SHALL, on its edge, set count=0, reset both pointers, clear halted, and discard any same-cycle input; a same-cycle read is void.
REQ-031 flush SHALL NOT clear err_sticky.
REQ-032 count SHALL never exceed 2 nor underflow below 0.

Reset
REQ-033 On rst=1 at a rising edge: count=0, pointers=0, halted=0, err_sticky=0; rst has priority over flush, write and read.
REQ-034 During and after reset: out_valid=0, out_instr=NOP_INSTR, out_pc_next=16'h0000, out_err=0, in_ready=1 once rst deasserts.
REQ-035 Storage array contents need not be reset; they SHALL never be visible while out_valid=0.

Verification
REQ-036 Reset, then in_valid=1 in_instr=16'hC123 in_pc_next=16'h0002, out_ready=0 -> next cycle out_valid=1, out_instr=16'hC123, count=1.
REQ-037 Two writes with out_ready=0 (16'h1111, 16'h2222) -> count=2, in_ready=0; assert out_ready one cycle -> out_instr=16'h2222, count=1, in_ready=1.
REQ-038 Steady stream with in_valid=out_ready=1 in ONE -> count stays 1, each word appears exactly one cycle after acceptance, no loss or duplication.
REQ-039 Accept 16'h0000 (HALT) -> halted=1 next cycle, in_ready=0; HALT drains with out_instr=16'h0000; pulse flush -> halted=0, in_ready=1.
REQ-040 FULL with flush=1 and in_valid=1 same cycle -> next cycle count=0, out_valid=0, out_instr=16'h0800, input not stored.
REQ-041 Accept entry with in_err=1, then flush -> err_sticky stays 1; assert rst -> err_sticky=0, all outputs at reset values.

Source files
------------

// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer: 2-entry skid FIFO between fetch and decode with halt/flush/error tracking
module fetch_decode_buffer #(
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc_next,
    input  logic        in_err,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc_next,
    output logic        out_err,
    output logic        halted,
    output logic        err_sticky,
    output logic [1:0]  count
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;
    occ_t        state;
    logic [15:0] instr_q [2];
    logic [15:0] pc_q [2];
    logic [1:0]  err_q;
    logic        wr_ptr, rd_ptr;
    logic        wr, rd;
    assign count     = state;
    assign out_valid = state != EMPTY;
    assign in_ready  = state != FULL && !halted && !flush;
    assign wr        = in_valid && in_ready;
    assign rd        = out_valid && out_ready;
    assign out_instr   = out_valid ? instr_q[rd_ptr] : NOP_INSTR;
    assign out_pc_next = out_valid ? pc_q[rd_ptr] : 16'h0000;
    assign out_err     = out_valid ? err_q[rd_ptr] : 1'b0;
    // Storage array: written on accepted input only, never reset (masked while empty)
    always_ff @(posedge clk) begin
        if (wr) begin
            instr_q[wr_ptr] <= in_instr;
            pc_q[wr_ptr]    <= in_pc_next;
            err_q[wr_ptr]   <= in_err;
        end
    end
    // Control: occupancy, pointers, halt and sticky error; flush voids same-cycle read/write
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            halted     <= 1'b0;
            err_sticky <= 1'b0;
        end else if (flush) begin
            state  <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            halted <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= ~wr_ptr;
                if (in_instr[15:11] == 5'b00000) halted <= 1'b1;
                if (in_err) err_sticky <= 1'b1;
            end
            if (rd) rd_ptr <= ~rd_ptr;
            if (wr && !rd) state <= occ_t'(state + 2'd1);
            else if (rd && !wr) state <= occ_t'(state - 2'd1);
        end
    end
endmodule
